// File: rtl/vga_buffer_view_pkg.sv
// rtl/vga_buffer_view_pkg.sv - timing, geometry and colour constants for the buffer-view renderer
package vga_buffer_view_pkg;

    localparam int H_TOTAL     = 800;
    localparam int H_SYNC      = 96;
    localparam int V_TOTAL     = 525;
    localparam int V_SYNC      = 2;
    localparam int X_VIS_START = 144;
    localparam int X_VIS_END   = 783;
    localparam int Y_VIS_START = 35;
    localparam int Y_VIS_END   = 514;
    localparam int COL_X0      = 200;
    localparam int COL_PITCH   = 60;
    localparam int SLOT_Y0     = 345;
    localparam int SLOT_PITCH  = 45;

    localparam int CNT_W = 10;

    localparam logic [7:0] COLOR_BLACK = 8'h00;
    localparam logic [7:0] COLOR_FILL  = 8'h1C;
    localparam logic [7:0] COLOR_FLASH = 8'hE0;

    typedef struct packed {
        int h_total;
        int h_sync;
        int v_total;
        int v_sync;
        int x_vis_start;
        int x_vis_end;
        int y_vis_start;
        int y_vis_end;
        int col_x0;
        int col_pitch;
        int slot_y0;
        int slot_pitch;
    } vga_geom_t;

    localparam vga_geom_t GEOM_DEFAULT = '{
        h_total: H_TOTAL, h_sync: H_SYNC, v_total: V_TOTAL, v_sync: V_SYNC,
        x_vis_start: X_VIS_START, x_vis_end: X_VIS_END,
        y_vis_start: Y_VIS_START, y_vis_end: Y_VIS_END,
        col_x0: COL_X0, col_pitch: COL_PITCH,
        slot_y0: SLOT_Y0, slot_pitch: SLOT_PITCH
    };

    // Sprite image used for empty slots, indexed (x-x0)*CELL + (y-y0).
    function automatic logic [7:0] sprite_word(input int unsigned addr);
        return 8'((addr * 32'd29 + 32'd7) % 32'd256);
    endfunction

endpackage

// File: rtl/vga_buffer_view_if.sv
// rtl/vga_buffer_view_if.sv - occupancy/drop inputs and video outputs of the buffer-view renderer
interface vga_buffer_view_if #(
    parameter int NUM_BUF = 4
);
    logic [NUM_BUF*4-1:0] i_occ;
    logic [NUM_BUF-1:0]   i_drop;
    logic                 o_hsync;
    logic                 o_vsync;
    logic [7:0]           o_color;
    logic                 o_frame_start;

    modport master (
        output i_occ, i_drop,
        input  o_hsync, o_vsync, o_color, o_frame_start
    );

    modport slave (
        input  i_occ, i_drop,
        output o_hsync, o_vsync, o_color, o_frame_start
    );
endinterface

// File: rtl/vga_buffer_view_sprite_rom.sv
// rtl/vga_buffer_view_sprite_rom.sv - synchronous-read sprite ROM, one clock of latency
module sprite_rom
    import vga_buffer_view_pkg::*;
#(
    parameter int CELL = 35,
    parameter int AW   = 11
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    output logic [7:0]    data_o
);
    localparam int WORDS = CELL * CELL;

    logic [7:0] data_q;

    always_ff @(posedge clk) begin
        data_q <= (int'(addr_i) < WORDS) ? sprite_word(32'(addr_i)) : COLOR_BLACK;
    end

    assign data_o = data_q;
endmodule

// File: rtl/vga_buffer_view.sv
// rtl/vga_buffer_view.sv - VGA renderer drawing one column of slots per buffer with drop flashes
module vga_buffer_view
    import vga_buffer_view_pkg::*;
#(
    parameter int        NUM_BUF      = 4,
    parameter int        DEPTH        = 6,
    parameter int        CELL         = 35,
    parameter int        FLASH_FRAMES = 30,
    parameter vga_geom_t GEOM         = GEOM_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    vga_buffer_view_if.slave bus
);
    localparam int ROM_WORDS = CELL * CELL;
    localparam int ROM_AW    = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;

    logic                    div_q;
    logic                    pix_en;
    logic [CNT_W-1:0]        x_q;
    logic [CNT_W-1:0]        y_q;
    logic [NUM_BUF-1:0][3:0] snap_q;
    logic [NUM_BUF-1:0][7:0] flash_q;

    logic              vis_d, hit_d, fill_d, border_d;
    logic [ROM_AW-1:0] addr_d;
    int                dx, dy;

    logic              vis1_q, hit1_q, fill1_q, border1_q, hs1_q, vs1_q, fs1_q;
    logic [ROM_AW-1:0] addr1_q;
    logic [7:0]        rom_data;
    logic [7:0]        color_d, color_q;
    logic              hs_q, vs_q, fs_q;

    assign pix_en = div_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            div_q <= ~div_q;
            if (pix_en) begin
                if (x_q == CNT_W'(GEOM.h_total - 1)) begin
                    x_q <= '0;
                    y_q <= (y_q == CNT_W'(GEOM.v_total - 1)) ? '0 : y_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end
        end
    end

    // Occupancy is frozen on the first line after the visible window so a frame never tears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_q <= '0;
        end else if (pix_en && y_q == CNT_W'(GEOM.y_vis_end + 1) && x_q == '0) begin
            for (int b = 0; b < NUM_BUF; b++) begin
                snap_q[b] <= (bus.i_occ[4*b +: 4] > 4'(DEPTH)) ? 4'(DEPTH) : bus.i_occ[4*b +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flash_q <= '0;
        end else begin
            for (int b = 0; b < NUM_BUF; b++) begin
                if (bus.i_drop[b]) begin
                    flash_q[b] <= 8'(FLASH_FRAMES);
                end else if (fs_q && flash_q[b] != 8'd0) begin
                    flash_q[b] <= flash_q[b] - 8'd1;
                end
            end
        end
    end

    always_comb begin
        vis_d    = (x_q >= CNT_W'(GEOM.x_vis_start)) && (x_q <= CNT_W'(GEOM.x_vis_end))
                && (y_q >= CNT_W'(GEOM.y_vis_start)) && (y_q <= CNT_W'(GEOM.y_vis_end));
        hit_d    = 1'b0;
        fill_d   = 1'b0;
        border_d = 1'b0;
        addr_d   = '0;
        dx       = 0;
        dy       = 0;
        for (int b = 0; b < NUM_BUF; b++) begin
            for (int s = 0; s < DEPTH; s++) begin
                dx = int'(x_q) - (GEOM.col_x0 + GEOM.col_pitch * b);
                dy = int'(y_q) - (GEOM.slot_y0 - GEOM.slot_pitch * s);
                if (dx >= 0 && dx < CELL && dy >= 0 && dy < CELL) begin
                    hit_d    = 1'b1;
                    fill_d   = (s < int'(snap_q[b]));
                    border_d = (flash_q[b] != 8'd0)
                            && (dx == 0 || dx == CELL - 1 || dy == 0 || dy == CELL - 1);
                    addr_d   = ROM_AW'(dx * CELL + dy);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vis1_q    <= 1'b0;
            hit1_q    <= 1'b0;
            fill1_q   <= 1'b0;
            border1_q <= 1'b0;
            addr1_q   <= '0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            fs1_q     <= 1'b0;
        end else if (pix_en) begin
            vis1_q    <= vis_d;
            hit1_q    <= hit_d;
            fill1_q   <= fill_d;
            border1_q <= border_d;
            addr1_q   <= addr_d;
            hs1_q     <= (x_q < CNT_W'(GEOM.h_sync));
            vs1_q     <= (y_q < CNT_W'(GEOM.v_sync));
            fs1_q     <= (x_q == '0) && (y_q == '0);
        end
    end

    sprite_rom #(
        .CELL (CELL),
        .AW   (ROM_AW)
    ) u_sprite_rom (
        .clk    (clk),
        .addr_i (addr1_q),
        .data_o (rom_data)
    );

    always_comb begin
        color_d = COLOR_BLACK;
        if (vis1_q && hit1_q) begin
            if (border1_q) begin
                color_d = COLOR_FLASH;
            end else if (fill1_q) begin
                color_d = COLOR_FILL;
            end else begin
                color_d = rom_data;
            end
        end
    end

    // Frame start is narrowed to the first clk of the pixel so it can drive the flash decrement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color_q <= COLOR_BLACK;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            fs_q <= pix_en & fs1_q;
            if (pix_en) begin
                color_q <= color_d;
                hs_q    <= hs1_q;
                vs_q    <= vs1_q;
            end
        end
    end

    assign bus.o_color       = color_q;
    assign bus.o_hsync       = hs_q;
    assign bus.o_vsync       = vs_q;
    assign bus.o_frame_start = fs_q;
endmodule

// File: tb/tb_vga_buffer_view.sv
// tb/tb_vga_buffer_view.sv - randomized frame-by-frame check of vga_buffer_view on a reduced raster
module tb_vga_buffer_view;
    import vga_buffer_view_pkg::*;

    localparam int NB    = 4;
    localparam int DEP   = 6;
    localparam int CL    = 3;
    localparam int FF    = 3;
    localparam int H_T   = 40;
    localparam int V_T   = 30;
    localparam int HS_W  = 4;
    localparam int VS_W  = 2;
    localparam int XV0   = 6;
    localparam int XV1   = 37;
    localparam int YV0   = 3;
    localparam int YV1   = 27;
    localparam int CX0   = 8;
    localparam int CPIT  = 5;
    localparam int SY0   = 22;
    localparam int SPIT  = 4;
    localparam int MID_ROW = 10;

    localparam vga_geom_t TB_GEOM = '{
        h_total: H_T, h_sync: HS_W, v_total: V_T, v_sync: VS_W,
        x_vis_start: XV0, x_vis_end: XV1, y_vis_start: YV0, y_vis_end: YV1,
        col_x0: CX0, col_pitch: CPIT, slot_y0: SY0, slot_pitch: SPIT
    };

    logic clk = 1'b0;
    logic reset;

    vga_buffer_view_if #(.NUM_BUF(NB)) bus ();

    vga_buffer_view #(
        .NUM_BUF      (NB),
        .DEPTH        (DEP),
        .CELL         (CL),
        .FLASH_FRAMES (FF),
        .GEOM         (TB_GEOM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         snap_m  [NB];
    int         flash_m [NB];
    logic [15:0] occ_now;
    logic [7:0] img [V_T][H_T];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sprite_ref(input int a);
        return 8'((a * 29 + 7) % 256);
    endfunction

    // Paint every slot rectangle onto a blank frame, clipped to the visible window.
    task automatic build_image();
        int px, py;
        for (int y = 0; y < V_T; y++)
            for (int x = 0; x < H_T; x++)
                img[y][x] = 8'h00;
        for (int b = 0; b < NB; b++) begin
            for (int s = 0; s < DEP; s++) begin
                for (int i = 0; i < CL; i++) begin
                    for (int j = 0; j < CL; j++) begin
                        px = CX0 + CPIT * b + i;
                        py = SY0 - SPIT * s + j;
                        if (px >= XV0 && px <= XV1 && py >= YV0 && py <= YV1) begin
                            if (flash_m[b] > 0 && (i == 0 || i == CL - 1 || j == 0 || j == CL - 1))
                                img[py][px] = 8'hE0;
                            else if (s < snap_m[b])
                                img[py][px] = 8'h1C;
                            else
                                img[py][px] = sprite_ref(i * CL + j);
                        end
                    end
                end
            end
        end
    endtask

    task automatic wait_fs(input int exp_n);
        int n;
        n = 0;
        while (bus.o_frame_start !== 1'b1 && n < 4 * H_T * V_T) begin
            @(negedge clk);
            n++;
        end
        chk("fs_latency", 32'(n), 32'(exp_n));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_color"}, 32'(bus.o_color), 32'h0);
        chk({tag, "_hsync"}, 32'(bus.o_hsync), 32'h0);
        chk({tag, "_vsync"}, 32'(bus.o_vsync), 32'h0);
        chk({tag, "_fs"},    32'(bus.o_frame_start), 32'h0);
    endtask

    // Entered on the sample where o_frame_start is expected; consumes two clocks per pixel.
    task automatic run_frame(input logic [15:0] occ_start, input bit mid_en, input logic [15:0] occ_mid,
                             input logic [3:0] drop_mask, input bit coincide, input int stop_at);
        int x, y;
        for (int b = 0; b < NB; b++) begin
            if (flash_m[b] > 0) flash_m[b]--;
            if (drop_mask[b]) flash_m[b] = FF;
        end
        build_image();
        for (int p = 0; p < H_T * V_T; p++) begin
            x = p % H_T;
            y = p / H_T;
            if (p == stop_at) return;
            chk($sformatf("color(%0d,%0d)", x, y), 32'(bus.o_color), 32'(img[y][x]));
            chk($sformatf("hsync(%0d,%0d)", x, y), 32'(bus.o_hsync), 32'(x < HS_W));
            chk($sformatf("vsync(%0d,%0d)", x, y), 32'(bus.o_vsync), 32'(y < VS_W));
            chk($sformatf("fs(%0d,%0d)", x, y), 32'(bus.o_frame_start), 32'(p == 0));
            if (p == 0) occ_now = occ_start;
            if (mid_en && y == MID_ROW && x == 0) occ_now = occ_mid;
            bus.i_occ = occ_now;
            if ((coincide && p == 0) || (!coincide && p == 1)) bus.i_drop = drop_mask;
            @(negedge clk);
            bus.i_drop = '0;
            chk($sformatf("color_hold(%0d,%0d)", x, y), 32'(bus.o_color), 32'(img[y][x]));
            chk($sformatf("fs_narrow(%0d,%0d)", x, y), 32'(bus.o_frame_start), 32'h0);
            @(negedge clk);
        end
        for (int b = 0; b < NB; b++) begin
            snap_m[b] = int'((occ_now >> (4 * b)) & 16'hF);
            if (snap_m[b] > DEP) snap_m[b] = DEP;
        end
    endtask

    initial begin
        logic [15:0] r_a, r_b, r_c;
        logic [3:0]  r_m;
        for (int b = 0; b < NB; b++) begin
            snap_m[b]  = 0;
            flash_m[b] = 0;
        end
        occ_now    = '0;
        bus.i_occ  = '0;
        bus.i_drop = '0;
        reset      = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;
        wait_fs(4);

        r_a = 16'($urandom());
        r_b = 16'($urandom());
        r_c = 16'($urandom());
        r_m = 4'($urandom()) | 4'b0100;

        run_frame(16'h0003, 1'b0, 16'h0, 4'h0, 1'b0, -1);
        run_frame(16'h0009, 1'b0, 16'h0, 4'h0, 1'b0, -1);
        run_frame(r_a, 1'b1, r_b, 4'h0, 1'b0, -1);
        run_frame(r_c, 1'b0, 16'h0, r_m, 1'b0, -1);
        run_frame(16'($urandom()), 1'b0, 16'h0, 4'h0, 1'b0, -1);
        run_frame(16'($urandom()), 1'b0, 16'h0, 4'b0100, 1'b1, -1);
        run_frame(16'($urandom()), 1'b0, 16'h0, 4'h0, 1'b0, -1);
        run_frame(16'($urandom()), 1'b0, 16'h0, 4'h0, 1'b0, -1);
        run_frame(16'($urandom()), 1'b0, 16'h0, 4'h0, 1'b0, -1);
        run_frame(16'($urandom()) | 16'h0F0F, 1'b0, 16'h0, 4'b0100, 1'b0, 15 * H_T + 20);

        reset = 1'b1;
        #1;
        chk_zero("midreset");
        repeat (3) begin
            @(negedge clk);
            chk_zero("midreset_hold");
        end
        reset = 1'b0;
        for (int b = 0; b < NB; b++) begin
            snap_m[b]  = 0;
            flash_m[b] = 0;
        end
        wait_fs(4);
        run_frame(16'($urandom()) | 16'h1111, 1'b0, 16'h0, 4'h0, 1'b0, -1);
        run_frame(16'($urandom()), 1'b0, 16'h0, 4'h0, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_buffer_view.md
VGA_BUFFER_VIEW -- requirements
Module: vga_buffer_view

Interface
REQ-001 The block SHALL have parameter NUM_BUF, default 4, meaning the number of displayed buffer columns (legal range 1..4).
REQ-002 The block SHALL have parameter DEPTH, default 6, meaning the slots per buffer (legal range 1..8).
REQ-003 The block SHALL have parameter CELL, default 35, meaning the cell edge in pixels.
REQ-004 The block SHALL have parameter FLASH_FRAMES, default 30, meaning the number of frames a drop highlight persists.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-006 clk  in  1  50 MHz system clock.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 i_occ  in  NUM_BUF*4  occupancy count per buffer; buffer b is bits [4b+3:4b]; values above DEPTH are clamped to DEPTH.
REQ-009 i_drop  in  NUM_BUF  one-clk pulse per buffer marking a dropped packet.
REQ-010 o_hsync  out  1  horizontal sync, high for 96 pixel counts.
REQ-011 o_vsync  out  1  vertical sync, high for 2 lines.
REQ-012 o_color  out  8  RGB332 pixel value.
REQ-013 o_frame_start  out  1  one-clk pulse at pixel (0,0).

Function
REQ-014 The block SHALL generate a pixel enable on every second clk; all counters advance only on the pixel enable.
REQ-015 counter_x SHALL count 0..799 and then wrap; counter_y SHALL increment when counter_x wraps, count 0..524, and then wrap (525 lines total).
REQ-016 The visible window SHALL be x in [144,783] and y in [35,514]; outside the window, o_color SHALL be 0.
REQ-017 Buffer b SHALL occupy a column at x0 = 200 + 60*b, with slot s (0 = bottom) at y0 = 345 - 45*s, each slot CELL x CELL pixels.
REQ-018 i_occ SHALL be sampled into a snapshot register only when counter_y == 515 and counter_x == 0, so that each frame renders a consistent occupancy.
REQ-019 In each slot with s < snapshot occ[b], the pixel SHALL be FILL color 8'h1C; in all other slots, the pixel SHALL be sprite_rom[(x-x0)*CELL + (y-y0)].
REQ-020 Each buffer SHALL have an 8-bit flash counter; an i_drop[b] pulse SHALL load FLASH_FRAMES, and the counter SHALL decrement once per o_frame_start while nonzero.
REQ-021 While flash[b] != 0, a pixel on the 1-pixel border of any slot of buffer b SHALL be 8'hE0, overriding REQ-019.
REQ-022 If i_drop[b] and o_frame_start coincide, the reload to FLASH_FRAMES SHALL take priority over the decrement.
REQ-023 Pixel generation SHALL be a 2-stage pipeline (stage 1: region, slot and ROM address decode; stage 2: ROM data and colour mux).
REQ-024 o_hsync, o_vsync and o_frame_start SHALL be delayed by the same 2 pixel-enable stages so that they stay aligned with o_color.
REQ-025 Pixels outside every cell but inside the visible window SHALL be 0.

Reset
REQ-026 On reset, the counters, divider, snapshot registers, flash counters and pipeline registers SHALL clear to 0.
REQ-027 During reset, o_hsync, o_vsync and o_frame_start SHALL be 0 and o_color SHALL be 0.
REQ-028 After reset is released, the first frame SHALL begin at (0,0) with snapshot occupancy 0, so all cells render as sprite.
REQ-029 Reset asserted mid-frame SHALL abandon the frame immediately, with no partial-line completion.

Structure
REQ-030 A shared package SHALL hold the timing constants (H_TOTAL 800, H_SYNC 96, V_TOTAL 525, V_SYNC 2, window bounds), the colour constants, and the column and slot pitch (60, 45).
REQ-031 The block SHALL contain one sub-module, sprite_rom: a synchronous-read 8-bit ROM of CELL*CELL words, initialised from a hex file, with 1-cycle latency.

Verification
REQ-032 Release reset, run 2 frames -> o_frame_start is pulsed every 800*525*2 clk; o_hsync is high for 192 clk per line; o_vsync is high for 2 lines.
REQ-033 Set i_occ[3:0]=3 for buffer 0 -> pixel (210,360) is 8'h1C and pixel (210,225) is the sprite value.
REQ-034 Set i_occ=9 with DEPTH=6 -> all 6 slots of buffer 0 are filled and no pixel outside the column is altered.
REQ-035 Change i_occ mid-frame at y=200 -> the rendered frame is unchanged until after line 515.
REQ-036 Pulse i_drop[2] -> the border pixel (320,345) is 8'hE0 for 30 frames, then reverts; a second pulse coinciding with o_frame_start reloads the count to 30.
REQ-037 Assert reset at x=400, y=300 -> outputs go to 0 immediately, and after release counting restarts at (0,0).
